// File: rtl/dram_sched_pkg.sv
// Shared types and constants for the DRAM row scheduler: FSM encoding,
// datapath operation codes, core/byte geometry and the per-row byte rotation.
package dram_sched_pkg;

    localparam int NUM_CORES = 16;
    localparam int BYTE_W    = 8;
    localparam int ROW_W     = 6;
    localparam int ERR_W     = 16;
    localparam int MISS_W    = $clog2(NUM_CORES + 1);

    localparam logic [1:0] IO_MODEL_IDLE = 2'b00;
    localparam logic [1:0] IO_MODEL_WR   = 2'b01;
    localparam logic [1:0] IO_MODEL_RD   = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_WAIT,
        RD_ISSUE,
        RD_WAIT,
        CHECK,
        NEXT,
        FINISH
    } sched_state_t;

    // Each row gets the base byte rotated left by its low three address bits.
    function automatic logic [BYTE_W-1:0] rotl_byte(input logic [BYTE_W-1:0] b,
                                                    input logic [2:0]        amt);
        logic [2*BYTE_W-1:0] dbl;
        dbl = {b, b} << amt;
        return dbl[2*BYTE_W-1:BYTE_W];
    endfunction

endpackage

// File: rtl/dram_sched_cmp.sv
// Compares every core's readback byte against the expected row byte and
// returns how many of the 16 cores disagree.
module dram_sched_cmp
    import dram_sched_pkg::*;
(
    input  logic [NUM_CORES*BYTE_W-1:0] rd_data,
    input  logic [BYTE_W-1:0]           exp_byte,
    output logic [MISS_W-1:0]           miss_cnt
);

    always_comb begin
        miss_cnt = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (rd_data[k*BYTE_W +: BYTE_W] != exp_byte) begin
                miss_cnt = miss_cnt + MISS_W'(1);
            end
        end
    end

endmodule

// File: rtl/dram_row_scheduler.sv
// Sweeps a row range: write a rotated pattern, read it back, count mismatching cores.
// Optional wait-state abort enabled by defining DRAM_SCHED_TIMEOUT_EN.
module dram_row_scheduler
    import dram_sched_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic         clk_100m,
    input  logic         rst,
    input  logic         start,
    input  logic [5:0]   row_first,
    input  logic [5:0]   row_last,
    input  logic [7:0]   pattern,
    output logic         io_en,
    output logic [1:0]   io_model,
    output logic [5:0]   wwl_add,
    output logic [5:0]   rwl_add,
    output logic [7:0]   wbl_byte,
    input  logic         wt_done,
    input  logic         rd_done,
    input  logic [127:0] rd_data,
    output logic         busy,
    output logic         done,
    output logic [15:0]  err_cnt,
    output logic [5:0]   fail_row,
    output logic         fail_vld,
    output logic         timeout
);

    sched_state_t                  state_q, state_d;
    logic [ROW_W-1:0]              row_q, row_d;
    logic [ROW_W-1:0]              row_last_q, row_last_d;
    logic [BYTE_W-1:0]             pattern_q, pattern_d;
    logic [NUM_CORES*BYTE_W-1:0]   rd_data_q, rd_data_d;
    logic [ERR_W-1:0]              err_cnt_q, err_cnt_d;
    logic [ROW_W-1:0]              fail_row_q, fail_row_d;
    logic                          fail_vld_q, fail_vld_d;
    logic [MISS_W-1:0]             miss_cnt;
    logic [ERR_W:0]                err_sum;

`ifdef DRAM_SCHED_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic              timeout_q, timeout_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              wait_expired;

    assign wait_expired = (wait_cnt_q == WAIT_W'(TIMEOUT_CYC - 1));
`endif

    dram_sched_cmp u_cmp (
        .rd_data  (rd_data_q),
        .exp_byte (wbl_byte),
        .miss_cnt (miss_cnt)
    );

    assign err_sum = {1'b0, err_cnt_q} + (ERR_W + 1)'(miss_cnt);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
        state_d    = state_q;
        row_d      = row_q;
        row_last_d = row_last_q;
        pattern_d  = pattern_q;
        rd_data_d  = rd_data_q;
        err_cnt_d  = err_cnt_q;
        fail_row_d = fail_row_q;
        fail_vld_d = fail_vld_q;
`ifdef DRAM_SCHED_TIMEOUT_EN
        timeout_d  = timeout_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    row_d      = row_first;
                    row_last_d = row_last;
                    pattern_d  = pattern;
                    err_cnt_d  = '0;
                    fail_vld_d = 1'b0;
`ifdef DRAM_SCHED_TIMEOUT_EN
                    timeout_d  = 1'b0;
`endif
                    state_d    = WR_ISSUE;
                end
            end
            WR_ISSUE: state_d = WR_WAIT;
            WR_WAIT: begin
                if (wt_done) begin
                    state_d = RD_ISSUE;
                end
`ifdef DRAM_SCHED_TIMEOUT_EN
                else if (wait_expired) begin
                    timeout_d = 1'b1;
                    state_d   = FINISH;
                end
`endif
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT: begin
                if (rd_done) begin
                    rd_data_d = rd_data;
                    state_d   = CHECK;
                end
`ifdef DRAM_SCHED_TIMEOUT_EN
                else if (wait_expired) begin
                    timeout_d = 1'b1;
                    state_d   = FINISH;
                end
`endif
            end
            CHECK: begin
                err_cnt_d = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
                if ((miss_cnt != '0) && !fail_vld_q) begin
                    fail_row_d = row_q;
                    fail_vld_d = 1'b1;
                end
                state_d = NEXT;
            end
            NEXT: begin
                if (row_q == row_last_q) begin
                    state_d = FINISH;
                end else begin
                    row_d   = row_q + ROW_W'(1);
                    state_d = WR_ISSUE;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef DRAM_SCHED_TIMEOUT_EN
        // Counter runs only while parked in a wait state; any exit clears it.
        wait_cnt_d = '0;
        if (((state_q == WR_WAIT) || (state_q == RD_WAIT)) && (state_d == state_q)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
`endif
    end

    always_ff @(posedge clk_100m) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= IDLE;
            row_q      <= '0;
            row_last_q <= '0;
            pattern_q  <= '0;
            rd_data_q  <= '0;
            err_cnt_q  <= '0;
            fail_row_q <= '0;
            fail_vld_q <= 1'b0;
`ifdef DRAM_SCHED_TIMEOUT_EN
            timeout_q  <= 1'b0;
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            row_last_q <= row_last_d;
            pattern_q  <= pattern_d;
            rd_data_q  <= rd_data_d;
            err_cnt_q  <= err_cnt_d;
            fail_row_q <= fail_row_d;
            fail_vld_q <= fail_vld_d;
`ifdef DRAM_SCHED_TIMEOUT_EN
            timeout_q  <= timeout_d;
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    always_comb begin
        io_model = IO_MODEL_IDLE;
        case (state_q)
            WR_ISSUE, WR_WAIT: io_model = IO_MODEL_WR;
            RD_ISSUE, RD_WAIT: io_model = IO_MODEL_RD;
            default:           io_model = IO_MODEL_IDLE;
        endcase
    end

    assign io_en    = (state_q == WR_ISSUE) || (state_q == RD_ISSUE);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FINISH);
    assign wbl_byte = rotl_byte(pattern_q, row_q[2:0]);
    assign wwl_add  = row_q;
    assign rwl_add  = row_q;
    assign err_cnt  = err_cnt_q;
    assign fail_row = fail_row_q;
    assign fail_vld = fail_vld_q;
`ifdef DRAM_SCHED_TIMEOUT_EN
    assign timeout  = timeout_q;
`else
    assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_dram_row_scheduler.sv
// Scoreboard bench for dram_row_scheduler: expected launches and end-of-sweep
// results are queued by the stimulus and checked by an independent monitor.
module tb_dram_row_scheduler;

    logic         clk_100m;
    logic         rst;
    logic         start;
    logic [5:0]   row_first;
    logic [5:0]   row_last;
    logic [7:0]   pattern;
    logic         io_en;
    logic [1:0]   io_model;
    logic [5:0]   wwl_add;
    logic [5:0]   rwl_add;
    logic [7:0]   wbl_byte;
    logic         wt_done;
    logic         rd_done;
    logic [127:0] rd_data;
    logic         busy;
    logic         done;
    logic [15:0]  err_cnt;
    logic [5:0]   fail_row;
    logic         fail_vld;
    logic         timeout;

    dram_row_scheduler #(.TIMEOUT_CYC(16)) dut (
        .clk_100m  (clk_100m),
        .rst       (rst),
        .start     (start),
        .row_first (row_first),
        .row_last  (row_last),
        .pattern   (pattern),
        .io_en     (io_en),
        .io_model  (io_model),
        .wwl_add   (wwl_add),
        .rwl_add   (rwl_add),
        .wbl_byte  (wbl_byte),
        .wt_done   (wt_done),
        .rd_done   (rd_done),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .err_cnt   (err_cnt),
        .fail_row  (fail_row),
        .fail_vld  (fail_vld),
        .timeout   (timeout)
    );

    initial clk_100m = 1'b0;
    always #5 clk_100m = ~clk_100m;

    typedef struct packed {
        logic [1:0] model;
        logic [5:0] addr;
        logic [7:0] wbl;
    } io_exp_t;

    typedef struct packed {
        logic [15:0] err;
        logic        fvld;
        logic [5:0]  frow;
        logic        tmo;
    } done_exp_t;

    io_exp_t   io_q[$];
    done_exp_t done_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    // Responder controls (written only by the stimulus process)
    logic       resp_en    = 1'b1;
    logic       corrupt_en = 1'b0;
    logic [5:0] corrupt_row = '0;
    logic       inject_rd  = 1'b0;

    // Responder state (written only by the responder process)
    int         pend_cnt = 0;
    int         inj_cnt  = 0;
    logic [1:0] pend_model;
    logic [7:0] pend_wbl;
    logic [5:0] pend_row;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic push_row(input logic [5:0] row, input logic [7:0] wbl);
        io_q.push_back('{model: 2'b01, addr: row, wbl: wbl});
        io_q.push_back('{model: 2'b10, addr: row, wbl: wbl});
    endtask

    task automatic push_done(input logic [15:0] err, input logic fvld,
                             input logic [5:0] frow, input logic tmo);
        done_q.push_back('{err: err, fvld: fvld, frow: frow, tmo: tmo});
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_io_en"},    io_en,    0);
        check({tag, "_io_model"}, io_model, 0);
        check({tag, "_wwl_add"},  wwl_add,  0);
        check({tag, "_rwl_add"},  rwl_add,  0);
        check({tag, "_wbl_byte"}, wbl_byte, 0);
        check({tag, "_busy"},     busy,     0);
        check({tag, "_done"},     done,     0);
        check({tag, "_err_cnt"},  err_cnt,  0);
        check({tag, "_fail_row"}, fail_row, 0);
        check({tag, "_fail_vld"}, fail_vld, 0);
        check({tag, "_timeout"},  timeout,  0);
    endtask

    // Called at a negedge; start is sampled on the following posedge, after
    // which the inputs are scrambled to show the sweep uses latched copies.
    task automatic launch(input logic [5:0] first, input logic [5:0] last, input logic [7:0] pat);
        start     = 1'b1;
        row_first = first;
        row_last  = last;
        pattern   = pat;
        @(negedge clk_100m);
        start     = 1'b0;
        row_first = 6'($urandom);
        row_last  = 6'($urandom);
        pattern   = 8'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int c0;
        int n;
        c0 = done_cnt;
        n  = 0;
        while (done_cnt == c0 && n < budget) begin
            @(negedge clk_100m);
            n++;
        end
        check("sweep_finished", (done_cnt != c0), 1);
        @(negedge clk_100m);
        check("idle_after_sweep", busy, 0);
    endtask

    task automatic run_sweep(input logic [5:0] first, input logic [5:0] last, input logic [7:0] pat);
        launch(first, last, pat);
        wait_done(1000);
        repeat (3) @(negedge clk_100m);
    endtask

    // Ideal datapath: completion five cycles after each launch, reads echo the row byte.
    initial begin
        wt_done = 1'b0;
        rd_done = 1'b0;
        rd_data = '0;
        forever begin
            @(negedge clk_100m);
            wt_done = 1'b0;
            rd_done = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    if (pend_model == 2'b01) begin
                        wt_done = 1'b1;
                    end else begin
                        rd_done = 1'b1;
                        rd_data = {16{pend_wbl}};
                        if (corrupt_en && pend_row == corrupt_row) begin
                            rd_data[31:24] = rd_data[31:24] ^ 8'h5A;
                            rd_data[79:72] = rd_data[79:72] ^ 8'h01;
                        end
                    end
                end
            end
            if (inj_cnt > 0) begin
                inj_cnt--;
                if (inj_cnt == 0) begin
                    rd_done = 1'b1;
                    rd_data = {16{8'hEE}};
                end
            end
            if (io_en && resp_en) begin
                pend_cnt   = 5;
                pend_model = io_model;
                pend_wbl   = wbl_byte;
                pend_row   = rwl_add;
                if (inject_rd && io_model == 2'b01) inj_cnt = 2;
            end
        end
    end

    // Monitor: every launch and every end-of-sweep pulse is matched against the queues.
    initial begin
        io_exp_t   ie;
        done_exp_t de;
        forever begin
            @(negedge clk_100m);
            if (!rst) begin
                if (io_en) begin
                    if (io_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL io_unexpected: got io_en model=%b row=%0d, required no launch",
                                 io_model, wwl_add);
                    end else begin
                        ie = io_q.pop_front();
                        check("io_model", io_model, ie.model);
                        check("wwl_add",  wwl_add,  ie.addr);
                        check("rwl_add",  rwl_add,  ie.addr);
                        check("wbl_byte", wbl_byte, ie.wbl);
                        check("busy_io",  busy,     1);
                    end
                end
                if (done) begin
                    done_cnt++;
                    if (done_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL done_unexpected: got done with err_cnt=%0d, required no done", err_cnt);
                    end else begin
                        de = done_q.pop_front();
                        check("err_cnt",   err_cnt,  de.err);
                        check("fail_vld",  fail_vld, de.fvld);
                        check("timeout",   timeout,  de.tmo);
                        check("busy_done", busy,     1);
                        check("io_model_finish", io_model, 0);
                        if (de.fvld) check("fail_row", fail_row, de.frow);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rst       = 1'b1;
        start     = 1'b0;
        row_first = '0;
        row_last  = '0;
        pattern   = '0;
        repeat (3) @(negedge clk_100m);
        check_reset_vals("por");
        rst = 1'b0;
        @(negedge clk_100m);

        // Basic 4-row sweep, pattern alternates with row parity
        push_row(6'd0, 8'h55); push_row(6'd1, 8'hAA);
        push_row(6'd2, 8'h55); push_row(6'd3, 8'hAA);
        push_done(16'd0, 1'b0, 6'd0, 1'b0);
        run_sweep(6'd0, 6'd3, 8'h55);

        // Wrapping sweep 62,63,0,1
        push_row(6'd62, 8'h60); push_row(6'd63, 8'hC0);
        push_row(6'd0,  8'h81); push_row(6'd1,  8'h03);
        push_done(16'd0, 1'b0, 6'd0, 1'b0);
        run_sweep(6'd62, 6'd1, 8'h81);

        // Cores 3 and 9 corrupted on row 2
        corrupt_en  = 1'b1;
        corrupt_row = 6'd2;
        push_row(6'd0, 8'h01); push_row(6'd1, 8'h02); push_row(6'd2, 8'h04);
        push_row(6'd3, 8'h08); push_row(6'd4, 8'h10); push_row(6'd5, 8'h20);
        push_done(16'd2, 1'b1, 6'd2, 1'b0);
        run_sweep(6'd0, 6'd5, 8'h01);
        corrupt_en = 1'b0;

        // Repeated start while busy and a stray rd_done during WR_WAIT
        inject_rd = 1'b1;
        push_row(6'd7, 8'h78); push_row(6'd8, 8'hF0);
        push_done(16'd0, 1'b0, 6'd0, 1'b0);
        launch(6'd7, 6'd8, 8'hF0);
        repeat (2) @(negedge clk_100m);
        start     = 1'b1;
        row_first = 6'd30;
        row_last  = 6'd31;
        pattern   = 8'hFF;
        @(negedge clk_100m);
        start = 1'b0;
        wait_done(1000);
        inject_rd = 1'b0;
        repeat (3) @(negedge clk_100m);

        // Reset during RD_WAIT, with start held high under reset
        push_row(6'd20, 8'hC3);
        launch(6'd20, 6'd25, 8'h3C);
        n = 0;
        while (!(io_en && io_model == 2'b10) && n < 100) begin
            @(negedge clk_100m);
            n++;
        end
        check("rd_issue_seen", (io_en && io_model == 2'b10), 1);
        repeat (2) @(negedge clk_100m);
        rst = 1'b1;
        @(negedge clk_100m);
        start     = 1'b1;
        row_first = 6'd40;
        row_last  = 6'd41;
        pattern   = 8'hA5;
        @(negedge clk_100m);
        start = 1'b0;
        check_reset_vals("rst_mid");
        rst = 1'b0;
        @(negedge clk_100m);
        check("rst_over_start", busy, 0);
        repeat (6) @(negedge clk_100m);
        push_row(6'd10, 8'h3C); push_row(6'd11, 8'h78);
        push_done(16'd0, 1'b0, 6'd0, 1'b0);
        run_sweep(6'd10, 6'd11, 8'h0F);

`ifdef DRAM_SCHED_TIMEOUT_EN
        // wt_done withheld: abort after 16 WR_WAIT cycles
        resp_en = 1'b0;
        io_q.push_back('{model: 2'b01, addr: 6'd5, wbl: 8'h22});
        push_done(16'd0, 1'b0, 6'd0, 1'b1);
        launch(6'd5, 6'd5, 8'h11);
        n = 0;
        while (!io_en && n < 50) begin
            @(negedge clk_100m);
            n++;
        end
        check("wr_issue_seen", io_en, 1);
        n = 0;
        do begin
            @(negedge clk_100m);
            n++;
        end while (!done && n < 40);
        check("timeout_done_cycle", n, 17);
        repeat (2) @(negedge clk_100m);
        check("timeout_sticky", timeout, 1);
        check("timeout_idle", busy, 0);
        resp_en = 1'b1;
`endif

        check("io_queue_drained",   io_q.size(),   0);
        check("done_queue_drained", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
